// File: rtl/acq_seq_pkg.sv
// acq_seq_pkg: one-hot state encoding and counter widths shared by the readout sequencer.
package acq_seq_pkg;
   localparam int BYTE_CNT_W = 11;
   localparam int TMO_CNT_W = 24;
   typedef enum logic [5:0] {
      IDLE    = 6'b000001,
      ARMED   = 6'b000010,
      SETTLE  = 6'b000100,
      PRESENT = 6'b001000,
      HANDOFF = 6'b010000,
      DONE    = 6'b100000
   } state_t;
endpackage

// File: rtl/acq_readout_sequencer.sv
// acq_readout_sequencer: arms storage capture, drains one record byte by byte onto a valid/ready link.
// TRIG_TIMEOUT_EN adds an ARMED-state timeout with a sticky TriggerTimeout output.
module acq_readout_sequencer
   import acq_seq_pkg::*;
#(
   parameter int BYTES_PER_RECORD = 1024,
   parameter int SETTLE_CYCLES = 2
`ifdef TRIG_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 2**24-1
`endif
) (
   input  logic       ReadClock,
   input  logic       Reset,
   input  logic       Arm,
   input  logic       Abort,
   output logic       TriggerEnable,
   input  logic       StorageDataReady,
   input  logic [7:0] StorageData,
   output logic       StorageReadEnable,
   output logic [7:0] TxData,
   output logic       TxValid,
   input  logic       TxReady,
   output logic       Busy,
   output logic       RecordDone,
`ifdef TRIG_TIMEOUT_EN
   output logic       TriggerTimeout,
`endif
   output logic       ShortRecord
);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

   state_t state, state_nxt;
   logic [BYTE_CNT_W-1:0] byte_cnt;
   logic [SET_W-1:0] settle_cnt;
   logic accept, finish, drop, advance, tmo_hit;

   assign accept = state == HANDOFF && TxReady;
   assign finish = accept && byte_cnt == BYTE_CNT_W'(BYTES_PER_RECORD - 1);
   // a completing accept beats a falling StorageDataReady; Abort beats both
   assign drop = !StorageDataReady && (state inside {SETTLE, PRESENT, HANDOFF}) && !finish && !Abort;
   assign advance = accept && !Abort && (StorageDataReady || finish);

`ifdef TRIG_TIMEOUT_EN
   logic [TMO_CNT_W-1:0] tmo_cnt;
   assign tmo_hit = state == ARMED && !StorageDataReady && tmo_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge ReadClock) begin
      tmo_cnt <= (Reset || state != ARMED) ? '0 : tmo_cnt + 1'b1;
      if (Reset || (state == IDLE && Arm))
         TriggerTimeout <= 1'b0;
      else if (tmo_hit && !Abort)
         TriggerTimeout <= 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge ReadClock)
      state <= Reset ? IDLE : state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = Arm ? ARMED : IDLE;
         ARMED:   state_nxt = StorageDataReady ? SETTLE : tmo_hit ? IDLE : ARMED;
         SETTLE:  state_nxt = settle_cnt == SET_W'(SETTLE_CYCLES - 1) ? PRESENT : SETTLE;
         PRESENT: state_nxt = HANDOFF;
         HANDOFF: state_nxt = !accept ? HANDOFF : finish ? DONE : SETTLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if ((Abort && state != IDLE) || drop)
         state_nxt = IDLE;
   end

   always_comb begin
      TriggerEnable = state == ARMED;
      Busy = state != IDLE;
      RecordDone = state == DONE;
   end

   always_ff @(posedge ReadClock) begin
      if (Reset) begin
         byte_cnt <= '0;
         settle_cnt <= '0;
         TxData <= '0;
         TxValid <= 1'b0;
         StorageReadEnable <= 1'b0;
         ShortRecord <= 1'b0;
      end else begin
         settle_cnt <= state == SETTLE ? settle_cnt + 1'b1 : '0;
         TxValid <= state_nxt == HANDOFF;
         StorageReadEnable <= advance;
         if (state == PRESENT)
            TxData <= StorageData;
         byte_cnt <= (state == IDLE || Abort) ? '0 : byte_cnt + BYTE_CNT_W'(advance);
         ShortRecord <= (state == IDLE && Arm) ? 1'b0 : ShortRecord | drop;
      end
   end
endmodule

// File: tb/tb_acq_readout_sequencer.sv
// tb_acq_readout_sequencer: vector table for the control path plus scoreboarded full-record runs.
module tb_acq_readout_sequencer;
   logic ReadClock = 1'b0, Reset = 1'b1, Arm = 1'b0, Abort = 1'b0;
   logic StorageDataReady = 1'b0, TxReady = 1'b0, srst = 1'b0;
   logic TriggerEnable, StorageReadEnable, TxValid, Busy, RecordDone, ShortRecord;
   logic [7:0] StorageData, TxData, sbyte, next_byte;
`ifdef TRIG_TIMEOUT_EN
   logic TriggerTimeout;
`endif
   logic [7:0] q[$];
   int vec = 0, miss = 0, accepted = 0, ren_cnt = 0, done_cnt = 0;

   typedef struct {
      bit rst, arm, abort, sdr, rdy;
      bit trig, busy, valid, ren, done;
   } vec_t;
   vec_t tbl[15];

   acq_readout_sequencer #(
      .BYTES_PER_RECORD(1024),
      .SETTLE_CYCLES(2)
`ifdef TRIG_TIMEOUT_EN
      , .TIMEOUT_CYCLES(100)
`endif
   ) dut (
      .ReadClock(ReadClock), .Reset(Reset), .Arm(Arm), .Abort(Abort),
      .TriggerEnable(TriggerEnable), .StorageDataReady(StorageDataReady),
      .StorageData(StorageData), .StorageReadEnable(StorageReadEnable),
      .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady), .Busy(Busy),
      .RecordDone(RecordDone),
`ifdef TRIG_TIMEOUT_EN
      .TriggerTimeout(TriggerTimeout),
`endif
      .ShortRecord(ShortRecord)
   );

   always #5 ReadClock = ~ReadClock;

   // storage model: registered byte counter advanced by each read-enable
   always @(posedge ReadClock)
      if (Reset || srst) sbyte <= 8'h00;
      else if (StorageReadEnable) sbyte <= sbyte + 8'h01;
   assign StorageData = sbyte;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_trig"}, TriggerEnable, 0);
      chk({tag, "_ren"}, StorageReadEnable, 0);
      chk({tag, "_txdata"}, TxData, 0);
      chk({tag, "_txvalid"}, TxValid, 0);
      chk({tag, "_busy"}, Busy, 0);
      chk({tag, "_done"}, RecordDone, 0);
      chk({tag, "_short"}, ShortRecord, 0);
   endtask

   // one clock: score the handshake seen before the edge, then sample #1 after it
   task automatic tick();
      logic acc, hold_pend;
      logic [7:0] hold_d;
      acc = (TxValid === 1'b1) && TxReady;
      if (acc) begin
         if (q.size() == 0) begin
            vec++;
            miss++;
            $display("FAIL sb_underflow: got byte %0h, expected none", TxData);
         end else
            chk("txdata", TxData, q.pop_front());
         accepted++;
      end
      hold_pend = (TxValid === 1'b1) && !TxReady && !Abort && !Reset && StorageDataReady;
      hold_d = TxData;
      @(posedge ReadClock);
      #1;
      if (hold_pend) begin
         chk("hold_valid", TxValid, 1);
         chk("hold_data", TxData, hold_d);
      end
      if (StorageReadEnable) begin
         ren_cnt++;
         q.push_back(next_byte);
         next_byte++;
      end
      if (RecordDone) done_cnt++;
   endtask

   task automatic run_record(input string tag, input bit rnd, input int drop_at, input int arm_at,
                             input int rst_at, input int exp_acc, input int exp_done, input bit exp_short);
      int n, guard;
      bit fired;
      accepted = 0; ren_cnt = 0; done_cnt = 0;
      q.delete();
      q.push_back(8'h00);
      next_byte = 8'h01;
      srst = 1'b1;
      tick();
      srst = 1'b0;
      Arm = 1'b1;
      tick();
      Arm = 1'b0;
      chk({tag, "_arm_trig"}, TriggerEnable, 1);
      chk({tag, "_arm_clears_short"}, ShortRecord, 0);
      repeat (9) tick();
      StorageDataReady = 1'b1;
      TxReady = 1'b0;
      n = 0;
      while (!TxValid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_first_valid_latency"}, n, 4);
      fired = 1'b0;
      guard = 0;
      while (Busy && guard < 20000) begin
         TxReady = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
         Arm = arm_at > 0 && !fired && accepted == arm_at;
         if (Arm) fired = 1'b1;
         if (drop_at > 0 && accepted == drop_at) StorageDataReady = 1'b0;
         if (rst_at > 0 && accepted == rst_at) begin
            Reset = 1'b1;
            tick();
            Reset = 1'b0;
            chk_zero({tag, "_midreset"});
            break;
         end
         tick();
         guard++;
      end
      Arm = 1'b0;
      TxReady = 1'b0;
      StorageDataReady = 1'b0;
      if (guard >= 20000) begin
         vec++;
         miss++;
         $display("FAIL %s_budget: still busy after %0d cycles, expected idle", tag, guard);
      end
      chk({tag, "_accepted"}, accepted, exp_acc);
      chk({tag, "_ren_pulses"}, ren_cnt, exp_acc);
      chk({tag, "_record_done"}, done_cnt, exp_done);
      chk({tag, "_short"}, ShortRecord, exp_short);
      chk({tag, "_busy_end"}, Busy, 0);
   endtask

   initial begin
      // rst arm abort sdr rdy | trig busy valid ren done
      tbl = '{
         '{1,0,0,0,0, 0,0,0,0,0}, '{0,0,0,0,0, 0,0,0,0,0}, '{0,1,0,0,0, 1,1,0,0,0},
         '{0,1,0,0,0, 1,1,0,0,0}, '{0,0,0,1,0, 0,1,0,0,0}, '{0,0,0,1,0, 0,1,0,0,0},
         '{0,0,0,1,0, 0,1,0,0,0}, '{0,0,0,1,0, 0,1,1,0,0}, '{0,0,0,1,0, 0,1,1,0,0},
         '{0,0,1,1,1, 0,0,0,0,0}, '{0,0,0,1,1, 0,0,0,0,0}, '{0,1,0,1,0, 1,1,0,0,0},
         '{0,0,0,1,0, 0,1,0,0,0}, '{0,0,1,1,0, 0,0,0,0,0}, '{0,0,0,0,0, 0,0,0,0,0}
      };
      tick();
      tick();
      chk_zero("reset");
      q.delete();
      q.push_back(8'h00);
      next_byte = 8'h01;
      for (int i = 0; i < 15; i++) begin
         {Reset, Arm, Abort, StorageDataReady, TxReady} =
            {tbl[i].rst, tbl[i].arm, tbl[i].abort, tbl[i].sdr, tbl[i].rdy};
         tick();
         chk($sformatf("row%0d_trig", i), TriggerEnable, tbl[i].trig);
         chk($sformatf("row%0d_busy", i), Busy, tbl[i].busy);
         chk($sformatf("row%0d_valid", i), TxValid, tbl[i].valid);
         chk($sformatf("row%0d_ren", i), StorageReadEnable, tbl[i].ren);
         chk($sformatf("row%0d_done", i), RecordDone, tbl[i].done);
      end
      {Reset, Arm, Abort, StorageDataReady, TxReady} = 5'b0;
      chk("table_no_ren", ren_cnt, 0);
      run_record("full", 1'b0, 0, 0, 0, 1024, 1, 1'b0);
      run_record("random_ready", 1'b1, 0, 0, 0, 1024, 1, 1'b0);
      run_record("drop500", 1'b0, 500, 0, 0, 500, 0, 1'b1);
      run_record("arm_mid", 1'b1, 0, 200, 0, 1024, 1, 1'b0);
      run_record("reset300", 1'b0, 0, 0, 300, 300, 0, 1'b0);
`ifdef TRIG_TIMEOUT_EN
      begin
         int n;
         Arm = 1'b1;
         tick();
         Arm = 1'b0;
         n = 0;
         while (Busy && n < 300) begin
            tick();
            n++;
         end
         chk("tmo_latency", n, 100);
         chk("tmo_flag", TriggerTimeout, 1);
         Arm = 1'b1;
         tick();
         Arm = 1'b0;
         chk("tmo_cleared", TriggerTimeout, 0);
         Abort = 1'b1;
         tick();
         Abort = 1'b0;
         chk("tmo_abort_idle", Busy, 0);
      end
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/acq_readout_sequencer.md
Name: acq_readout_sequencer

Overview:
Single-clock controller that sequences one acquisition/readout cycle of the four-channel accumulator storage block.
- Arms the capture path via a trigger-gate output and waits for the storage to report a complete record.
- Drains the record byte by byte through the storage read-enable, meeting its registered-output timing.
- Presents the bytes to the host link on a valid/ready handshake.
- Sits between the host command decoder and the storage block, in the ReadClock domain.

Parameters:
BYTES_PER_RECORD, 1024, bytes drained per record (4 channels x 128 samples x 2 bytes); 11-bit counter.
SETTLE_CYCLES, 2, idle cycles after each storage read-enable before the next byte is sampled; must be >= 2.
TIMEOUT_CYCLES, 2**24-1, ARMED-state timeout; used only with TRIG_TIMEOUT_EN.

Ports:
ReadClock  in  1  sole clock; all logic on its rising edge
Reset  in  1  synchronous, active-high reset
Arm  in  1  one-cycle host command: start acquisition
Abort  in  1  one-cycle host command: return to IDLE
TriggerEnable  out  1  gates the fast trigger into storage; high only in ARMED
StorageDataReady  in  1  storage reports a record available and in readout
StorageData  in  8  storage registered byte output
StorageReadEnable  out  1  one-cycle pulse: advance storage to next byte
TxData  out  8  byte to host link
TxValid  out  1  TxData valid
TxReady  in  1  host link accepts byte when TxValid & TxReady
Busy  out  1  high in any state except IDLE
RecordDone  out  1  one-cycle pulse when a full record has been sent
ShortRecord  out  1  sticky; StorageDataReady fell before BYTES_PER_RECORD bytes; cleared by Arm or Reset

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0; settle counter 0.
- States:
  - IDLE: Arm -> ARMED.
  - ARMED: TriggerEnable=1. StorageDataReady=1 -> SETTLE, with TriggerEnable dropping the same edge.
  - SETTLE: counts SETTLE_CYCLES, then -> PRESENT.
  - PRESENT: registers TxData<=StorageData, sets TxValid=1, -> HANDOFF.
  - HANDOFF: holds TxData/TxValid stable until TxReady. On the accept edge: TxValid<=0, StorageReadEnable<=1 for exactly one cycle, counter+1. Then if counter+1==BYTES_PER_RECORD -> DONE, else -> SETTLE.
  - DONE: RecordDone=1 for one cycle -> IDLE.
- Latency: Arm to TriggerEnable = 1 cycle. StorageDataReady to first TxValid = SETTLE_CYCLES+2 cycles. Accept to next TxValid = SETTLE_CYCLES+2 cycles.
- Arm outside IDLE is ignored; ShortRecord clears only on an accepted Arm.
- Abort, any state except IDLE: -> IDLE next edge. TriggerEnable, TxValid and StorageReadEnable go to 0. Counter clears and RecordDone is not pulsed. Abort has priority over Arm and over a same-cycle handshake accept; that byte is not counted and no read-enable is issued.
- StorageDataReady low in SETTLE/PRESENT/HANDOFF before the count completes: set ShortRecord, drop TxValid, -> IDLE, no RecordDone.
  - Exception: in HANDOFF, an accept that completes the count wins; the record finishes normally.
- Counter never wraps; it clears on entry to ARMED.
- Reset mid-operation overrides everything, including Abort.

Optional Feature:
TRIG_TIMEOUT_EN
- Defined:
  - A 24-bit counter runs in ARMED and clears on entry to ARMED.
  - When it reaches TIMEOUT_CYCLES with StorageDataReady still low: -> IDLE, and output TriggerTimeout (1 bit, sticky, cleared by Arm/Reset) sets.
- Undefined: no counter; ARMED waits indefinitely; the TriggerTimeout port is absent.

Decomposition:
- Package acq_seq_pkg holds:
  - state encoding constants (IDLE, ARMED, SETTLE, PRESENT, HANDOFF, DONE), one-hot, 6 bits;
  - counter width constants (BYTE_CNT_W=11, TMO_CNT_W=24).
- No sub-module: the FSM and counters live in one module. The timeout counter is inline, under the macro.

Test Plan:
- Reset, then Arm; StorageDataReady rises 10 cycles later; model storage returns a byte counter and TxReady is held 1 -> 1024 bytes 0x00..0xFF x4, 1024 StorageReadEnable pulses, one RecordDone, Busy low after DONE.
- TxReady toggled randomly (30% duty) -> TxData/TxValid stable while TxReady=0; byte order intact; first TxValid exactly 4 cycles after StorageDataReady rises.
- StorageDataReady dropped after byte 500 accepted -> ShortRecord=1, return to IDLE, no RecordDone; next Arm clears ShortRecord.
- Abort in HANDOFF with TxReady=1 on the same cycle -> no read-enable pulse, counter 0, IDLE next cycle, TriggerEnable=0.
- Arm pulsed mid-readout -> ignored; record completes; Reset at byte 300 -> all outputs 0 on the next edge.
- TRIG_TIMEOUT_EN with TIMEOUT_CYCLES=100, no StorageDataReady -> TriggerTimeout=1 and IDLE 100 cycles after ARMED entry; cleared by the next Arm.
